_id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage of the 5-stage MIPS core. Sits directly downstream of `_control_unit` and the register file: it latches the decoded control bits, operands and register specifiers into the ID/EX pipeline register. It detects load-use hazards and raises a stall toward PC/IF-ID while inserting a bubble. It also honours branch flush and a global hold, and counts inserted bubbles.

---
 rtl/_id_ex_stage_pkg.sv | 38 +++
 rtl/_hazard_detect.sv | 26 ++
 rtl/_id_ex_stage.sv | 178 +++++++++++++++++
 tb/tb__id_ex_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/_id_ex_stage_pkg.sv
// Shared MIPS decode definitions for the ID/EX stage.
// Contents: opcode constants, ALUOp encodings, the packed control bundle
// carried from ID into EX, the bubble control value and a saturating
// 32-bit increment used by the bubble counter.
package _id_ex_stage_pkg;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OpcR    = 6'b000000;
    localparam logic [5:0] OpcLw   = 6'b100011;
    localparam logic [5:0] OpcSw   = 6'b101011;
    localparam logic [5:0] OpcBeq  = 6'b000100;
    localparam logic [5:0] OpcAddi = 6'b001000;

    // ALUOp encodings
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // A bubble must not write anything or branch; the remaining selects are
    // zeroed as well so a bubble always looks the same downstream.
    localparam ctrl_t CtrlBubble = '0;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/_hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Raises hz_o when the load sitting in EX writes a non-zero register that
// the instruction in ID names as rs or rt. rt is always compared, even for
// instructions that do not read it, which can only cost a spare bubble.
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_rt_i : registered ID/EX contents
//   id_valid_i, id_rs_i, id_rt_i       : instruction currently in ID
//   hz_o                               : load-use hazard
module _hazard_detect
    import _id_ex_stage_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic             ex_valid_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    output logic             hz_o
);

    assign hz_o = ex_valid_i & ex_mem_read_i & id_valid_i & (ex_rt_i != '0) &
                  ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));

endmodule

// File: rtl/_id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core.
// Latches decoded control, operands and register specifiers, inserts a
// bubble on a load-use hazard (raising stall toward PC and IF/ID) or on a
// branch flush, freezes on hold, and counts hazard bubbles (saturating).
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   hold, flush           : global freeze, wrong-path kill of ID
//   id_*                  : control from _control_unit, operands, fields
//   ex_*, ex_valid        : registered ID/EX contents
//   stall                 : combinational load-use stall
//   bubble_cnt            : hazard bubbles inserted, saturating
module _id_ex_stage
    import _id_ex_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_RegDst,
    input  logic              id_ALUSrc,
    input  logic              id_MemToReg,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_Branch,
    input  logic [1:0]        id_ALUOp,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [5:0]        id_funct,
    output logic              ex_valid,
    output logic              ex_RegDst,
    output logic              ex_ALUSrc,
    output logic              ex_MemToReg,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_Branch,
    output logic [1:0]        ex_ALUOp,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [5:0]        ex_funct,
    output logic              stall,
    output logic [31:0]       bubble_cnt
);

    ctrl_t             id_ctrl;
    ctrl_t             ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc4_q, pc4_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [5:0]        funct_q, funct_d;
    logic [31:0]       bubble_cnt_q, bubble_cnt_d;
    logic              hz;

    assign id_ctrl = '{
        reg_dst:    id_RegDst,
        alu_src:    id_ALUSrc,
        mem_to_reg: id_MemToReg,
        reg_write:  id_RegWrite,
        mem_read:   id_MemRead,
        mem_write:  id_MemWrite,
        branch:     id_Branch,
        alu_op:     id_ALUOp
    };

    _hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rt_i       (rt_q),
        .id_valid_i    (id_valid),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .hz_o          (hz)
    );

    // A flush redirects fetch, so stalling the wrong-path instruction is moot.
    assign stall = hz & ~flush;

    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        pc4_d        = pc4_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        funct_d      = funct_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!hold) begin
            // Datapath fields always follow ID; only control decides validity.
            pc4_d   = id_pc4;
            rd1_d   = id_rd1;
            rd2_d   = id_rd2;
            imm_d   = id_imm;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            funct_d = id_funct;
            if (flush) begin
                valid_d = 1'b0;
                ctrl_d  = CtrlBubble;
            end else if (hz) begin
                valid_d      = 1'b0;
                ctrl_d       = CtrlBubble;
                bubble_cnt_d = sat_inc32(bubble_cnt_q);
            end else begin
                valid_d = id_valid;
                ctrl_d  = id_valid ? id_ctrl : CtrlBubble;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            pc4_q        <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            funct_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            pc4_q        <= pc4_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            funct_q      <= funct_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_RegDst   = ctrl_q.reg_dst;
    assign ex_ALUSrc   = ctrl_q.alu_src;
    assign ex_MemToReg = ctrl_q.mem_to_reg;
    assign ex_RegWrite = ctrl_q.reg_write;
    assign ex_MemRead  = ctrl_q.mem_read;
    assign ex_MemWrite = ctrl_q.mem_write;
    assign ex_Branch   = ctrl_q.branch;
    assign ex_ALUOp    = ctrl_q.alu_op;
    assign ex_pc4      = pc4_q;
    assign ex_rd1      = rd1_q;
    assign ex_rd2      = rd2_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_rd       = rd_q;
    assign ex_funct    = funct_q;
    assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb__id_ex_stage.sv
// Directed bench for _id_ex_stage: a vector table for the single-cycle
// behaviour plus hand-written sequences for R-type field capture, counter
// saturation and reset in the middle of a stall.
module tb__id_ex_stage;
    import _id_ex_stage_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int NV = 21;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, hold, flush, id_valid;
    logic              id_RegDst, id_ALUSrc, id_MemToReg, id_RegWrite;
    logic              id_MemRead, id_MemWrite, id_Branch;
    logic [1:0]        id_ALUOp;
    logic [DATA_W-1:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic [5:0]        id_funct;
    logic              ex_valid, ex_RegDst, ex_ALUSrc, ex_MemToReg, ex_RegWrite;
    logic              ex_MemRead, ex_MemWrite, ex_Branch;
    logic [1:0]        ex_ALUOp;
    logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]        ex_funct;
    logic              stall;
    logic [31:0]       bubble_cnt;

    _id_ex_stage #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hold        (hold),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_RegDst   (id_RegDst),
        .id_ALUSrc   (id_ALUSrc),
        .id_MemToReg (id_MemToReg),
        .id_RegWrite (id_RegWrite),
        .id_MemRead  (id_MemRead),
        .id_MemWrite (id_MemWrite),
        .id_Branch   (id_Branch),
        .id_ALUOp    (id_ALUOp),
        .id_pc4      (id_pc4),
        .id_rd1      (id_rd1),
        .id_rd2      (id_rd2),
        .id_imm      (id_imm),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_funct    (id_funct),
        .ex_valid    (ex_valid),
        .ex_RegDst   (ex_RegDst),
        .ex_ALUSrc   (ex_ALUSrc),
        .ex_MemToReg (ex_MemToReg),
        .ex_RegWrite (ex_RegWrite),
        .ex_MemRead  (ex_MemRead),
        .ex_MemWrite (ex_MemWrite),
        .ex_Branch   (ex_Branch),
        .ex_ALUOp    (ex_ALUOp),
        .ex_pc4      (ex_pc4),
        .ex_rd1      (ex_rd1),
        .ex_rd2      (ex_rd2),
        .ex_imm      (ex_imm),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_rd       (ex_rd),
        .ex_funct    (ex_funct),
        .stall       (stall),
        .bubble_cnt  (bubble_cnt)
    );

    typedef struct {
        logic        rst_n, hold, flush, valid;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rd1;
        logic        e_stall, e_valid, e_rw, e_mr, e_mw;
        logic [1:0]  e_aluop;
        logic        chk_rd1;
        logic [31:0] e_rd1;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [NV];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        input logic r, h, f, v, input logic [5:0] op,
        input logic [4:0] rs, rt, rd, input logic [31:0] rd1,
        input logic es, ev, erw, emr, emw, input logic [1:0] eop,
        input logic crd1, input logic [31:0] erd1, input logic [31:0] ecnt);
        vec_t t;
        t.rst_n = r;  t.hold = h;  t.flush = f;  t.valid = v;  t.op = op;
        t.rs = rs;  t.rt = rt;  t.rd = rd;  t.rd1 = rd1;
        t.e_stall = es;  t.e_valid = ev;  t.e_rw = erw;  t.e_mr = emr;  t.e_mw = emw;
        t.e_aluop = eop;  t.chk_rd1 = crd1;  t.e_rd1 = erd1;  t.e_cnt = ecnt;
        return t;
    endfunction

    // Reference control unit for the five supported opcodes.
    function automatic ctrl_t ctrl_of(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OpcR:    begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = AluOpFunct; end
            OpcLw:   begin
                c.alu_src = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.mem_read = 1'b1;
                c.alu_op = AluOpAdd;
            end
            OpcSw:   begin c.alu_src = 1'b1; c.mem_write = 1'b1; c.alu_op = AluOpAdd; end
            OpcBeq:  begin c.branch = 1'b1; c.alu_op = AluOpSub; end
            OpcAddi: begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = AluOpAdd; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs, rt, rd,
                         input logic [31:0] rd1);
        ctrl_t c;
        c = ctrl_of(op);
        id_valid    = v;
        id_RegDst   = c.reg_dst;
        id_ALUSrc   = c.alu_src;
        id_MemToReg = c.mem_to_reg;
        id_RegWrite = c.reg_write;
        id_MemRead  = c.mem_read;
        id_MemWrite = c.mem_write;
        id_Branch   = c.branch;
        id_ALUOp    = c.alu_op;
        id_pc4      = rd1 + 32'd4;
        id_rd1      = rd1;
        id_rd2      = rd1 + 32'd2;
        id_imm      = rd1 + 32'd100;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_funct    = 6'h20;
    endtask

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // rst hold flush valid op rs rt rd rd1 | stall valid rw mr mw aluop chk rd1 cnt
        vecs[0]  = mk(0, 0, 0, 1, OpcR,    1, 2, 3,  9,  0, 0, 0, 0, 0, 2'b00, 1,   0, 0);
        vecs[1]  = mk(1, 0, 0, 1, OpcR,    1, 2, 3,  5,  0, 1, 1, 0, 0, 2'b10, 1,   5, 0);
        vecs[2]  = mk(1, 0, 0, 1, OpcLw,   1, 8, 0, 11,  0, 1, 1, 1, 0, 2'b00, 1,  11, 0);
        vecs[3]  = mk(1, 0, 0, 1, OpcR,    8, 9, 10, 21, 1, 0, 0, 0, 0, 2'b00, 0,   0, 1);
        vecs[4]  = mk(1, 0, 0, 1, OpcR,    8, 9, 10, 21, 0, 1, 1, 0, 0, 2'b10, 1,  21, 1);
        vecs[5]  = mk(1, 0, 0, 1, OpcLw,   2, 0, 0, 30,  0, 1, 1, 1, 0, 2'b00, 1,  30, 1);
        vecs[6]  = mk(1, 0, 0, 1, OpcR,    0, 0, 4, 40,  0, 1, 1, 0, 0, 2'b10, 1,  40, 1);
        vecs[7]  = mk(1, 0, 0, 1, OpcLw,   3, 8, 0, 50,  0, 1, 1, 1, 0, 2'b00, 1,  50, 1);
        vecs[8]  = mk(1, 0, 1, 1, OpcR,    4, 8, 5, 60,  0, 0, 0, 0, 0, 2'b00, 0,   0, 1);
        vecs[9]  = mk(1, 0, 0, 1, OpcSw,   5, 6, 0, 70,  0, 1, 0, 0, 1, 2'b00, 1,  70, 1);
        vecs[10] = mk(1, 1, 0, 1, OpcR,    7, 7, 6, 80,  0, 1, 0, 0, 1, 2'b00, 1,  70, 1);
        vecs[11] = mk(1, 1, 1, 1, OpcR,    7, 7, 6, 81,  0, 1, 0, 0, 1, 2'b00, 1,  70, 1);
        vecs[12] = mk(1, 1, 0, 1, OpcBeq,  7, 7, 6, 82,  0, 1, 0, 0, 1, 2'b00, 1,  70, 1);
        vecs[13] = mk(1, 0, 0, 1, OpcR,    1, 2, 3, 90,  0, 1, 1, 0, 0, 2'b10, 1,  90, 1);
        vecs[14] = mk(1, 0, 0, 0, OpcLw,   1, 8, 0, 95,  0, 0, 0, 0, 0, 2'b00, 0,   0, 1);
        vecs[15] = mk(1, 0, 0, 1, OpcLw,   1, 8, 0, 100, 0, 1, 1, 1, 0, 2'b00, 1, 100, 1);
        vecs[16] = mk(1, 1, 0, 1, OpcR,    8, 2, 3, 105, 1, 1, 1, 1, 0, 2'b00, 1, 100, 1);
        vecs[17] = mk(1, 0, 0, 1, OpcR,    8, 2, 3, 105, 1, 0, 0, 0, 0, 2'b00, 0,   0, 2);
        vecs[18] = mk(1, 0, 0, 1, OpcR,    8, 2, 3, 105, 0, 1, 1, 0, 0, 2'b10, 1, 105, 2);
        vecs[19] = mk(1, 0, 0, 1, OpcBeq,  1, 2, 0, 120, 0, 1, 0, 0, 0, 2'b01, 1, 120, 2);
        vecs[20] = mk(1, 0, 0, 1, OpcAddi, 1, 9, 0, 130, 0, 1, 1, 0, 0, 2'b00, 1, 130, 2);

        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        drive(1'b0, OpcR, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            rst_n = vecs[i].rst_n;
            hold  = vecs[i].hold;
            flush = vecs[i].flush;
            drive(vecs[i].valid, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rd1);
            #1;
            chk($sformatf("v%0d stall", i), 160'(stall), 160'(vecs[i].e_stall));
            step();
            chk($sformatf("v%0d ex_valid", i), 160'(ex_valid), 160'(vecs[i].e_valid));
            chk($sformatf("v%0d ctrl{rw,mr,mw,aluop}", i),
                160'({ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUOp}),
                160'({vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_aluop}));
            chk($sformatf("v%0d bubble_cnt", i), 160'(bubble_cnt), 160'(vecs[i].e_cnt));
            if (vecs[i].chk_rd1) chk($sformatf("v%0d ex_rd1", i), 160'(ex_rd1), 160'(vecs[i].e_rd1));
            if (i == 0) begin
                chk("reset all ex_* zero",
                    160'({ex_valid, ex_RegDst, ex_ALUSrc, ex_MemToReg, ex_RegWrite, ex_MemRead,
                          ex_MemWrite, ex_Branch, ex_ALUOp, ex_pc4, ex_rd1, ex_rd2, ex_imm,
                          ex_rs, ex_rt, ex_rd, ex_funct}), 160'(0));
            end
            if (i == 19) chk("beq ex_Branch", 160'(ex_Branch), 160'(1));
        end

        // R-type capture of every field
        drive(1'b1, OpcR, 5'd1, 5'd2, 5'd3, 32'd5);
        step();
        chk("rtype regdst/alusrc/memtoreg/branch",
            160'({ex_RegDst, ex_ALUSrc, ex_MemToReg, ex_Branch}), 160'(4'b1000));
        chk("rtype rs/rt/rd/funct", 160'({ex_rs, ex_rt, ex_rd, ex_funct}),
            160'({5'd1, 5'd2, 5'd3, 6'h20}));
        chk("rtype pc4/rd2/imm", 160'({ex_pc4, ex_rd2, ex_imm}), 160'({32'd9, 32'd7, 32'd105}));

        // Saturation: preload the counter just below the top
        drive(1'b1, OpcLw, 5'd1, 5'd8, 5'd0, 32'd200);
        step();
        chk("lw memtoreg", 160'({ex_MemToReg, ex_rt}), 160'({1'b1, 5'd8}));
        force dut.bubble_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt_q;
        drive(1'b1, OpcR, 5'd8, 5'd2, 5'd3, 32'd210);
        #1;
        chk("sat1 stall", 160'(stall), 160'(1));
        step();
        chk("sat1 bubble_cnt", 160'(bubble_cnt), 160'(32'hFFFF_FFFF));
        drive(1'b1, OpcLw, 5'd1, 5'd8, 5'd0, 32'd220);
        step();
        drive(1'b1, OpcR, 5'd2, 5'd8, 5'd3, 32'd230);
        #1;
        chk("sat2 stall", 160'(stall), 160'(1));
        step();
        chk("sat2 bubble_cnt", 160'(bubble_cnt), 160'(32'hFFFF_FFFF));

        // Reset in the middle of a stall
        drive(1'b1, OpcLw, 5'd1, 5'd8, 5'd0, 32'd240);
        step();
        drive(1'b1, OpcR, 5'd8, 5'd2, 5'd3, 32'd250);
        rst_n = 1'b0;
        #1;
        chk("pre-reset stall", 160'(stall), 160'(1));
        step();
        chk("post-reset stall", 160'(stall), 160'(0));
        chk("post-reset bubble_cnt", 160'(bubble_cnt), 160'(0));
        chk("post-reset all ex_* zero",
            160'({ex_valid, ex_RegDst, ex_ALUSrc, ex_MemToReg, ex_RegWrite, ex_MemRead,
                  ex_MemWrite, ex_Branch, ex_ALUOp, ex_pc4, ex_rd1, ex_rd2, ex_imm,
                  ex_rs, ex_rt, ex_rd, ex_funct}), 160'(0));
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
